// File: rtl/id_decode_pkg.sv
// Shared definitions for the ID stage: opcode/funct encodings, one-hot op
// indices and the decoder result payload.
package id_decode_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FIELD_W = 6;
  localparam int unsigned NUM_OPS = 12;

  // Primary opcodes, instr[31:26]
  localparam logic [FIELD_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [FIELD_W-1:0] OPC_ORI   = 6'b001101;
  localparam logic [FIELD_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [FIELD_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [FIELD_W-1:0] OPC_BEQ   = 6'b000100;
  localparam logic [FIELD_W-1:0] OPC_LUI   = 6'b001111;
  localparam logic [FIELD_W-1:0] OPC_JAL   = 6'b000011;

  // R-type function codes, instr[5:0]
  localparam logic [FIELD_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FIELD_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FIELD_W-1:0] FN_SLLV = 6'b000100;
  localparam logic [FIELD_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FIELD_W-1:0] FN_JR   = 6'b001000;

  // Bit positions inside the one-hot op vector
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_SLLV = 2;
  localparam int unsigned OP_SLT  = 3;
  localparam int unsigned OP_JR   = 4;
  localparam int unsigned OP_ORI  = 5;
  localparam int unsigned OP_LW   = 6;
  localparam int unsigned OP_SW   = 7;
  localparam int unsigned OP_BEQ  = 8;
  localparam int unsigned OP_LUI  = 9;
  localparam int unsigned OP_JAL  = 10;
  localparam int unsigned OP_NOP  = 11;

  // Decoder result: one-hot op plus illegal flag (op is zero when ill is set)
  typedef struct packed {
    logic [NUM_OPS-1:0] op;
    logic               ill;
  } dec_t;

  // One-hot vector with only bit idx set
  function automatic logic [NUM_OPS-1:0] op_bit(input int unsigned idx);
    return NUM_OPS'(1) << idx;
  endfunction

endpackage

// File: rtl/id_op_decoder.sv
// Purely combinational MIPS op decoder.
// Ports:
//   instr  - instruction word
//   dec_c  - {one-hot op, illegal flag}
module id_op_decoder
  import id_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec_c
);

  logic [FIELD_W-1:0] opcode;
  logic [FIELD_W-1:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // All-zero word is NOP and must win over the R-type funct table (funct 0 is
  // otherwise illegal here).
  always_comb begin
    dec_c = '0;
    if (instr == '0) begin
      dec_c.op = op_bit(OP_NOP);
    end else begin
      unique case (opcode)
        OPC_RTYPE: begin
          unique case (funct)
            FN_ADD:  dec_c.op = op_bit(OP_ADD);
            FN_SUB:  dec_c.op = op_bit(OP_SUB);
            FN_SLLV: dec_c.op = op_bit(OP_SLLV);
            FN_SLT:  dec_c.op = op_bit(OP_SLT);
            FN_JR:   dec_c.op = op_bit(OP_JR);
            default: dec_c.ill = 1'b1;
          endcase
        end
        OPC_ORI: dec_c.op = op_bit(OP_ORI);
        OPC_LW:  dec_c.op = op_bit(OP_LW);
        OPC_SW:  dec_c.op = op_bit(OP_SW);
        OPC_BEQ: dec_c.op = op_bit(OP_BEQ);
        OPC_LUI: dec_c.op = op_bit(OP_LUI);
        OPC_JAL: dec_c.op = op_bit(OP_JAL);
        default: dec_c.ill = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/id_decode_stage.sv
// Registered instruction-decode stage: decodes IF beats into a one-hot op,
// presents them to EX through an output register backed by a one-entry skid
// buffer, supports flush and counts completed output transfers.
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc - IF-side handshake and beat
//   flush                           - kill all held beats
//   out_valid/out_ready             - EX-side handshake
//   out_op/out_ill/out_instr/out_pc - registered decoded beat
//   dec_cnt                         - completed output transfers (wraps)
module id_decode_stage
  import id_decode_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned OP_W  = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic               out_ill,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   dec_cnt
);

  dec_t in_dec_c;

  logic               skid_valid;
  logic [OP_W-1:0]    skid_op;
  logic               skid_ill;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic in_xfer;
  logic out_xfer;
  logic load_out;

  id_op_decoder u_dec (
    .instr (in_instr),
    .dec_c (in_dec_c)
  );

  // Ready depends only on held state and flush, never on out_ready.
  assign in_ready = !skid_valid && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign load_out = !out_valid || out_xfer;

  // Output register and skid buffer. When the skid holds a beat in_ready is
  // low, so a skid drain never coincides with a new input transfer and
  // ordering is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_ill    <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_op    <= '0;
      skid_ill   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_op     <= skid_op;
        out_ill    <= skid_ill;
        out_instr  <= skid_instr;
        out_pc     <= skid_pc;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_valid  <= 1'b1;
        out_op     <= OP_W'(in_dec_c.op);
        out_ill    <= in_dec_c.ill;
        out_instr  <= in_instr;
        out_pc     <= in_pc;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (in_xfer) begin
      // Output held and stalled: park the new beat in the skid.
      skid_valid <= 1'b1;
      skid_op    <= OP_W'(in_dec_c.op);
      skid_ill   <= in_dec_c.ill;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
    end
  end

  // Transfer counter; a transfer in a flush cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (out_xfer) begin
      dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
module tb_id_decode_stage;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned OP_W  = 12;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic              out_ill;
  logic [31:0]       out_instr;
  logic [PC_W-1:0]   out_pc;
  logic [CNT_W-1:0]  dec_cnt;

  // Second instance with a 4-bit counter, driven by the same stimulus
  logic              in_ready4;
  logic              out_valid4;
  logic [OP_W-1:0]   out_op4;
  logic              out_ill4;
  logic [31:0]       out_instr4;
  logic [PC_W-1:0]   out_pc4;
  logic [3:0]        dec_cnt4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } beat_t;

  beat_t       q[$];
  int unsigned m_cnt = 0;

  id_decode_stage #(.PC_W(PC_W), .OP_W(OP_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_ill(out_ill), .out_instr(out_instr), .out_pc(out_pc),
    .dec_cnt(dec_cnt)
  );

  id_decode_stage #(.PC_W(PC_W), .OP_W(OP_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_op(out_op4),
    .out_ill(out_ill4), .out_instr(out_instr4), .out_pc(out_pc4),
    .dec_cnt(dec_cnt4)
  );

  always #5 clk = ~clk;

  // Reference decode straight from the instruction table: {ill, op[11:0]}
  function automatic logic [12:0] ref_dec(input logic [31:0] i);
    logic [5:0] opc;
    logic [5:0] fn;
    opc = i[31:26];
    fn  = i[5:0];
    if (i == 32'h0) return {1'b0, 12'h800};
    case (opc)
      6'h00: begin
        case (fn)
          6'h20:   return {1'b0, 12'h001};
          6'h22:   return {1'b0, 12'h002};
          6'h04:   return {1'b0, 12'h004};
          6'h2A:   return {1'b0, 12'h008};
          6'h08:   return {1'b0, 12'h010};
          default: return {1'b1, 12'h000};
        endcase
      end
      6'h0D:   return {1'b0, 12'h020};
      6'h23:   return {1'b0, 12'h040};
      6'h2B:   return {1'b0, 12'h080};
      6'h04:   return {1'b0, 12'h100};
      6'h0F:   return {1'b0, 12'h200};
      6'h03:   return {1'b0, 12'h400};
      default: return {1'b1, 12'h000};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the queue model for the current cycle
  task automatic model_cmp();
    logic [12:0] d;
    if (!rst_n) return;
    chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2 && !flush));
    chk("m_dec_cnt", 64'(dec_cnt), 64'(16'(m_cnt)));
    chk("m_dec_cnt4", 64'(dec_cnt4), 64'(4'(m_cnt)));
    if (q.size() > 0) begin
      d = ref_dec(q[0].instr);
      chk("m_out_op", 64'(out_op), 64'(d[11:0]));
      chk("m_out_ill", 64'(out_ill), 64'(d[12]));
      chk("m_out_instr", 64'(out_instr), 64'(q[0].instr));
      chk("m_out_pc", 64'(out_pc), 64'(q[0].pc));
    end
  endtask

  // Advance the model across one rising edge using the inputs seen there
  task automatic model_step();
    bit    ir;
    beat_t b;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      return;
    end
    ir = (q.size() < 2) && !flush;
    if (q.size() > 0 && out_ready) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (flush) begin
      q.delete();
    end else if (in_valid && ir) begin
      b.instr = in_instr;
      b.pc    = in_pc;
      q.push_back(b);
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the rising edge
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    model_cmp();
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [31:0] stream [0:5];

  initial begin
    stream[0] = 32'h00221820; stream[1] = 32'h03E00008; stream[2] = 32'h34011234;
    stream[3] = 32'h8C220004; stream[4] = 32'hAC220008; stream[5] = 32'h3C01ABCD;

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_op", 64'(out_op), 64'h0);
    chk("rst_out_pc", 64'(out_pc), 64'h0);
    chk("rst_dec_cnt", 64'(dec_cnt), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming add, jr, ori with EX always ready
    cyc(1, 32'h00221820, 32'h100, 1, 0);
    chk("add_op", 64'(out_op), 64'h001);
    chk("add_pc", 64'(out_pc), 64'h100);
    cyc(1, 32'h03E00008, 32'h104, 1, 0);
    chk("jr_op", 64'(out_op), 64'h010);
    cyc(1, 32'h34011234, 32'h108, 1, 0);
    chk("ori_op", 64'(out_op), 64'h020);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("stream_cnt", 64'(dec_cnt), 64'd3);
    chk("stream_drained", 64'(out_valid), 64'h0);

    // lw then NOP into a stalled output: lw held, NOP in skid
    cyc(1, 32'h8C220004, 32'h200, 0, 0);
    cyc(1, 32'h00000000, 32'h204, 0, 0);
    cyc(1, 32'h34011234, 32'h208, 0, 0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk("stall_op", 64'(out_op), 64'h040);
    chk("stall_instr", 64'(out_instr), 64'h8C220004);
    chk("stall_in_ready", 64'(in_ready), 64'h0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("skid_nop_op", 64'(out_op), 64'h800);
    chk("skid_nop_pc", 64'(out_pc), 64'h204);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("stall_cnt", 64'(dec_cnt), 64'd5);
    chk("stall_drained", 64'(out_valid), 64'h0);

    // Illegal encodings
    cyc(1, 32'h00000001, 32'h300, 1, 0);
    chk("ill1_ill", 64'(out_ill), 64'h1);
    chk("ill1_op", 64'(out_op), 64'h0);
    cyc(1, 32'hFC000000, 32'h304, 1, 0);
    chk("ill2_ill", 64'(out_ill), 64'h1);
    chk("ill2_op", 64'(out_op), 64'h0);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Output and skid full, flush with a beat offered
    cyc(1, 32'h00221820, 32'h400, 0, 0);
    cyc(1, 32'h00221822, 32'h404, 0, 0);
    cyc(1, 32'h34011234, 32'h408, 0, 1);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    chk("flush_cnt", 64'(dec_cnt), 64'd7);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("flush_no_accept", 64'(out_valid), 64'h0);
    // Flush coinciding with an output transfer still counts it
    cyc(1, 32'h0000202A, 32'h500, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 1);
    chk("flush_xfer_cnt", 64'(dec_cnt), 64'd8);
    cyc(0, 32'h0, 32'h0, 1, 0);

    // Counter wrap on the 4-bit instance after a fresh reset
    rst_n = 1'b0; #3; rst_n = 1'b1;
    q.delete(); m_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(1, stream[i % 6], 32'h1000 + 32'(i * 4), 1, 0);
    end
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("wrap_cnt4", 64'(dec_cnt4), 64'd1);
    chk("wrap_cnt16", 64'(dec_cnt), 64'd17);

    // Asynchronous reset in the middle of a stall
    cyc(1, 32'h8C220004, 32'h600, 0, 0);
    cyc(1, 32'h00221820, 32'h604, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_cnt = 0;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_out_op", 64'(out_op), 64'h0);
    chk("arst_out_instr", 64'(out_instr), 64'h0);
    chk("arst_out_pc", 64'(out_pc), 64'h0);
    chk("arst_cnt", 64'(dec_cnt), 64'h0);
    chk("arst_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 32'h1022FFFF, 32'h700, 1, 0);
    chk("beq_op", 64'(out_op), 64'h100);
    chk("beq_valid", 64'(out_valid), 64'h1);
    cyc(0, 32'h0, 32'h0, 1, 0);
    chk("beq_cnt", 64'(dec_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered MIPS instruction-decode stage for the pipelined CPU.
- Accepts fetched instruction/PC beats from IF with a valid/ready handshake and decodes opcode and funct into a one-hot operation vector plus an illegal flag.
- Presents decoded beats to EX through an output register backed by a one-entry skid buffer.
- Supersedes the flat R-type funct decoder: covers R-type and I/J-type ops, supports stall, flush and a decode counter.

Parameters:
- PC_W, 32, width of carried PC.
- OP_W, 12, width of one-hot op vector; indices fixed in package.
- CNT_W, 16, width of decoded-beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  kill all held beats (branch/jump redirect).
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  EX accepts beat.
- out_op  out  OP_W  one-hot operation.
- out_ill  out  1  no op matched.
- out_instr  out  32  registered instruction, for field extraction by EX.
- out_pc  out  PC_W  registered PC.
- dec_cnt  out  CNT_W  count of completed output transfers.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_op=0, out_ill=0, out_instr=0, out_pc=0, dec_cnt=0, skid empty. in_ready=1 once rst_n=1.
- Decode (combinational, on in_instr; opcode=[31:26], funct=[5:0]):
  - in_instr==0 → NOP, checked first.
  - opcode 000000 with funct 100000 → ADD, 100010 → SUB, 000100 → SLLV, 101010 → SLT, 001000 → JR. Any other funct → illegal.
  - opcode 001101 → ORI, 100011 → LW, 101011 → SW, 000100 → BEQ, 001111 → LUI, 000011 → JAL. Any other opcode → illegal.
  - Illegal: op=0, ill=1. Exactly one op bit is set otherwise.
- Transfers: an input transfer is in_valid&&in_ready; an output transfer is out_valid&&out_ready.
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle) if the output register is free.
- in_ready is driven as !skid_valid && !flush; it is registered-state based with no combinational path from out_ready.
- Output register loads when empty or when an output transfer occurs. Source is the skid entry if the skid is valid, else the input beat.
- Skid fills when an input transfer occurs while the output register holds a beat and out_ready=0. Skid drains into the output register on the next output transfer.
- Order is strictly preserved: skid beat before any newer input.
- out_* stay stable while out_valid=1 and out_ready=0.
- flush=1 (synchronous): at the next edge out_valid=0 and skid empty. No input transfer occurs during flush. An output transfer in the same cycle still counts in dec_cnt. Flush has priority over all loads.
- dec_cnt increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-operation discards all beats immediately.

Decomposition:
- Package id_decode_pkg holds:
  - opcode and funct localparams;
  - op index constants OP_ADD=0, OP_SUB=1, OP_SLLV=2, OP_SLT=3, OP_JR=4, OP_ORI=5, OP_LW=6, OP_SW=7, OP_BEQ=8, OP_LUI=9, OP_JAL=10, OP_NOP=11.
- One sub-module, id_op_decoder: purely combinational instr → {op, ill}. The skid and output register stay in the top level.

Test Plan:
- Reset then stream 0x00221820 (add), 0x03E00008 (jr), 0x34011234 (ori) with out_ready=1 → out_op = 0x001, 0x010, 0x020 on consecutive cycles, 1-cycle latency, dec_cnt=3.
- Beat 0x8C220004 (lw) then 0x00000000 with out_ready=0 for 3 cycles → lw held stable, NOP in skid, in_ready=0. Release → op 0x040, then 0x800; no loss or reorder.
- 0x00000001 and 0xFC000000 → out_ill=1, out_op=0 for both.
- Output and skid both full, pulse flush with in_valid=1 → next cycle out_valid=0, in_ready=1, the input beat is not accepted, dec_cnt unchanged.
- CNT_W=4: 17 transfers → dec_cnt=1.
- Drop rst_n mid-stall between edges → outputs clear immediately. After release, first beat 0x1022FFFF (beq) → op 0x100.
